// File: rtl/ir_queue_pkg.sv
// Shared widths, field positions and bench knobs for the instruction queue.
// Instructions are laid out as {opcode, source_reg1, source_reg2, dest_reg}.
package ir_queue_pkg;

    localparam int OPCODE_WIDTH = 3;
    localparam int ADDR_WIDTH   = 6;
    localparam int INST_WIDTH   = OPCODE_WIDTH + 3 * ADDR_WIDTH;

    localparam int DEST_LSB   = 0;
    localparam int SRC2_LSB   = ADDR_WIDTH;
    localparam int SRC1_LSB   = 2 * ADDR_WIDTH;
    localparam int OPCODE_LSB = 3 * ADDR_WIDTH;

    localparam int IR_DEPTH = 4;

    localparam int NUM_IR_TEST = 10;
    localparam int PERIOD      = 10;
    localparam int DUTY        = 5;

    function automatic logic [INST_WIDTH-1:0] make_inst(
        input logic [OPCODE_WIDTH-1:0] op,
        input logic [ADDR_WIDTH-1:0]   src1,
        input logic [ADDR_WIDTH-1:0]   src2,
        input logic [ADDR_WIDTH-1:0]   dest
    );
        return {op, src1, src2, dest};
    endfunction

endpackage

// File: rtl/ir_queue_mem.sv
// Queue storage: registered write, asynchronous read so the head is visible
// in the same cycle the read pointer points at it. Contents are never reset.
module ir_queue_mem
    import ir_queue_pkg::*;
#(
    parameter int DEPTH = IR_DEPTH,
    parameter int WIDTH = INST_WIDTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/ir_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO with field
// slicing of the head and a RAW flag against the last issued destination.
module ir_queue #(
    parameter int OPCODE_WIDTH = ir_queue_pkg::OPCODE_WIDTH,
    parameter int ADDR_WIDTH   = ir_queue_pkg::ADDR_WIDTH,
    parameter int DEPTH        = ir_queue_pkg::IR_DEPTH
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0]       ram_inst_out,
    input  logic                                       ram_inst_valid,
    output logic                                       ir_ready,
    output logic                                       ir_valid,
    input  logic                                       decode_ready,
    input  logic                                       flush,
    output logic [OPCODE_WIDTH-1:0]                    opcode,
    output logic [ADDR_WIDTH-1:0]                      source_reg1,
    output logic [ADDR_WIDTH-1:0]                      source_reg2,
    output logic [ADDR_WIDTH-1:0]                      dest_reg,
    output logic [$clog2(DEPTH+1)-1:0]                 count,
    output logic                                       raw_hazard
);

    localparam int INST_WIDTH = OPCODE_WIDTH + 3 * ADDR_WIDTH;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [ADDR_WIDTH-1:0] last_dest_reg;
    logic                  last_dest_valid_reg;
    logic [INST_WIDTH-1:0] head;
    logic                  push;
    logic                  pop;

    // Handshake flags decode from the occupancy register only.
    assign ir_ready = (count_reg != FULL_COUNT);
    assign ir_valid = (count_reg != '0);
    assign push     = ram_inst_valid & ir_ready;
    assign pop      = ir_valid & decode_ready;
    assign count    = count_reg;

    ir_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (INST_WIDTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr_reg),
        .wdata (ram_inst_out),
        .raddr (rd_ptr_reg),
        .rdata (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg          <= '0;
            rd_ptr_reg          <= '0;
            count_reg           <= '0;
            last_dest_reg       <= '0;
            last_dest_valid_reg <= 1'b0;
        end else if (flush) begin
            // Last_Dest keeps its value; only its valid bit is dropped.
            wr_ptr_reg          <= '0;
            rd_ptr_reg          <= '0;
            count_reg           <= '0;
            last_dest_valid_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg          <= rd_ptr_reg + PTR_W'(1);
                last_dest_reg       <= head[ADDR_WIDTH-1:0];
                last_dest_valid_reg <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        opcode      = '0;
        source_reg1 = '0;
        source_reg2 = '0;
        dest_reg    = '0;
        if (ir_valid) begin
            opcode      = head[INST_WIDTH-1:3*ADDR_WIDTH];
            source_reg1 = head[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
            source_reg2 = head[2*ADDR_WIDTH-1:ADDR_WIDTH];
            dest_reg    = head[ADDR_WIDTH-1:0];
        end
    end

    // Informational only: the queue never stalls on a hazard.
    assign raw_hazard = ir_valid & last_dest_valid_reg &
                        ((source_reg1 == last_dest_reg) | (source_reg2 == last_dest_reg));

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue: stimulus pushes expected pops into a queue,
// a negedge monitor compares every popped head against it.
module tb_ir_queue;
    import ir_queue_pkg::*;

    localparam int CNT_W = $clog2(IR_DEPTH + 1);

    typedef struct {
        logic [INST_WIDTH-1:0] inst;
        logic                  haz;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [INST_WIDTH-1:0]   ram_inst_out;
    logic                    ram_inst_valid;
    logic                    ir_ready;
    logic                    ir_valid;
    logic                    decode_ready;
    logic                    flush;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [ADDR_WIDTH-1:0]   source_reg1;
    logic [ADDR_WIDTH-1:0]   source_reg2;
    logic [ADDR_WIDTH-1:0]   dest_reg;
    logic [CNT_W-1:0]        count;
    logic                    raw_hazard;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops_seen = 0;

    ir_queue dut (
        .clk            (clk),
        .rst            (rst),
        .ram_inst_out   (ram_inst_out),
        .ram_inst_valid (ram_inst_valid),
        .ir_ready       (ir_ready),
        .ir_valid       (ir_valid),
        .decode_ready   (decode_ready),
        .flush          (flush),
        .opcode         (opcode),
        .source_reg1    (source_reg1),
        .source_reg2    (source_reg2),
        .dest_reg       (dest_reg),
        .count          (count),
        .raw_hazard     (raw_hazard)
    );

    always begin
        #(PERIOD - DUTY) clk = 1'b1;
        #(DUTY)          clk = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s value=%0h t=%0t", name, act, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [INST_WIDTH-1:0] inst, input logic haz);
        exp_t e;
        e.inst = inst;
        e.haz  = haz;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && !flush && ir_valid && decode_ready) begin
            pops_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", int'({opcode, source_reg1, source_reg2, dest_reg}), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pop_inst", int'({opcode, source_reg1, source_reg2, dest_reg}), int'(e.inst));
                chk("pop_raw", int'(raw_hazard), int'(e.haz));
            end
        end
    end

    initial begin
        logic [INST_WIDTH-1:0] inst_a;
        logic [INST_WIDTH-1:0] inst;

        rst = 1'b1;
        ram_inst_out = '0;
        ram_inst_valid = 1'b0;
        decode_ready = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        chk("rst_ir_valid", int'(ir_valid), 0);
        chk("rst_ir_ready", int'(ir_ready), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_fields", int'({opcode, source_reg1, source_reg2, dest_reg}), 0);
        chk("rst_raw", int'(raw_hazard), 0);
        rst = 1'b0;
        tick();

        // Single push and field slicing
        inst_a = 21'b101_000011_000101_000111;
        ram_inst_valid = 1'b1;
        ram_inst_out = inst_a;
        push_exp(inst_a, 1'b0);
        tick();
        ram_inst_valid = 1'b0;
        chk("a_ir_valid", int'(ir_valid), 1);
        chk("a_opcode", int'(opcode), 5);
        chk("a_src1", int'(source_reg1), 3);
        chk("a_src2", int'(source_reg2), 5);
        chk("a_dest", int'(dest_reg), 7);
        chk("a_count", int'(count), 1);
        chk("a_raw", int'(raw_hazard), 0);
        decode_ready = 1'b1;
        tick();
        decode_ready = 1'b0;
        chk("a_popped_count", int'(count), 0);

        // RAW: last dest 7, B reads 7 in src2; C reads 1,2 with last dest 9
        ram_inst_valid = 1'b1;
        ram_inst_out = make_inst(3'd2, 6'd1, 6'd7, 6'd9);
        push_exp(ram_inst_out, 1'b1);
        tick();
        chk("b_raw_head", int'(raw_hazard), 1);
        ram_inst_out = make_inst(3'd3, 6'd1, 6'd2, 6'd4);
        push_exp(ram_inst_out, 1'b0);
        tick();
        ram_inst_valid = 1'b0;
        decode_ready = 1'b1;
        tick();
        tick();
        decode_ready = 1'b0;

        // Fill to DEPTH, reject a fifth offer, drain in order
        ram_inst_valid = 1'b1;
        for (int i = 0; i < IR_DEPTH; i++) begin
            ram_inst_out = make_inst(3'(i), 6'(10 + i), 6'(20 + i), 6'(30 + i));
            push_exp(ram_inst_out, 1'b0);
            tick();
        end
        chk("full_count", int'(count), IR_DEPTH);
        chk("full_ir_ready", int'(ir_ready), 0);
        ram_inst_out = make_inst(3'd7, 6'd63, 6'd63, 6'd63);
        tick();
        chk("full_reject_count", int'(count), IR_DEPTH);
        ram_inst_valid = 1'b0;
        decode_ready = 1'b1;
        tick();
        chk("full_pop_ready", int'(ir_ready), 1);
        for (int i = 1; i < IR_DEPTH; i++) tick();
        decode_ready = 1'b0;
        chk("drain_count", int'(count), 0);

        // Simultaneous push/pop at count 2 across pointer wrap
        ram_inst_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ram_inst_out = make_inst(3'(k), 6'(40 + k), 6'(20 + k), 6'(k));
            push_exp(ram_inst_out, 1'b0);
            tick();
        end
        decode_ready = 1'b1;
        for (int k = 2; k < NUM_IR_TEST + 2; k++) begin
            ram_inst_out = make_inst(3'(k), 6'(40 + k), 6'(20 + k), 6'(k));
            push_exp(ram_inst_out, 1'b0);
            tick();
            chk("swap_count", int'(count), 2);
        end
        ram_inst_valid = 1'b0;
        tick();
        tick();
        decode_ready = 1'b0;
        chk("swap_drain_count", int'(count), 0);

        // Flush at count 3 beats a concurrent push and pop
        ram_inst_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ram_inst_out = make_inst(3'd6, 6'(i), 6'(i), 6'(i));
            tick();
        end
        chk("pre_flush_count", int'(count), 3);
        flush = 1'b1;
        decode_ready = 1'b1;
        ram_inst_out = make_inst(3'd1, 6'd1, 6'd1, 6'd1);
        tick();
        flush = 1'b0;
        decode_ready = 1'b0;
        ram_inst_valid = 1'b0;
        chk("flush_count", int'(count), 0);
        chk("flush_ir_valid", int'(ir_valid), 0);
        chk("flush_fields", int'({opcode, source_reg1, source_reg2, dest_reg}), 0);
        chk("flush_raw", int'(raw_hazard), 0);

        // Last dest (11) invalidated by flush: no hazard on a matching source
        ram_inst_valid = 1'b1;
        ram_inst_out = make_inst(3'd1, 6'd11, 6'd11, 6'd5);
        push_exp(ram_inst_out, 1'b0);
        tick();
        ram_inst_valid = 1'b0;
        decode_ready = 1'b1;
        tick();
        decode_ready = 1'b0;

        // Asynchronous reset mid-cycle at count 2
        ram_inst_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ram_inst_out = make_inst(3'd4, 6'(50 + i), 6'(50 + i), 6'(50 + i));
            tick();
        end
        ram_inst_valid = 1'b0;
        chk("pre_rst_count", int'(count), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ir_valid", int'(ir_valid), 0);
        chk("async_rst_count", int'(count), 0);
        tick();
        rst = 1'b0;
        chk("post_rst_ir_ready", int'(ir_ready), 1);
        ram_inst_valid = 1'b1;
        ram_inst_out = make_inst(3'd2, 6'd5, 6'd5, 6'd6);
        push_exp(ram_inst_out, 1'b0);
        tick();
        ram_inst_valid = 1'b0;
        chk("post_rst_count", int'(count), 1);
        decode_ready = 1'b1;
        tick();
        decode_ready = 1'b0;
        tick();
        tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("pops_seen", pops_seen, 5 + IR_DEPTH + NUM_IR_TEST + 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
Parametrised instruction register that replaces the single-entry IR with a DEPTH-entry instruction queue. It sits between RAM instruction fetch and decode. Fetch and decode are decoupled by valid/ready handshakes. The block slices the head instruction into opcode and register fields, and flags a read-after-write (RAW) dependency on the previously issued instruction. It also supports a synchronous flush for control-flow changes.

Parameters:
OPCODE_WIDTH, 3, opcode field width.
ADDR_WIDTH, 6, width of each register-address field.
DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
INST_WIDTH, derived localparam equal to OPCODE_WIDTH+3*ADDR_WIDTH (21 with defaults); not overridable.

Ports:
Clk  in  1  clock; all state updates on the rising edge.
Reset  in  1  asynchronous, active-high reset.
Ram_Inst_Out  in  INST_WIDTH  fetched instruction.
Ram_Inst_Valid  in  1  fetch side offers Ram_Inst_Out this cycle.
IR_Ready  out  1  queue can accept an instruction.
IR_Valid  out  1  head entry holds a valid instruction.
Decode_Ready  in  1  decode consumes the head this cycle.
Flush  in  1  synchronous discard of all entries.
Opcode  out  OPCODE_WIDTH  head bits [INST_WIDTH-1 : 3*ADDR_WIDTH].
Source_Reg1  out  ADDR_WIDTH  head bits [3*ADDR_WIDTH-1 : 2*ADDR_WIDTH].
Source_Reg2  out  ADDR_WIDTH  head bits [2*ADDR_WIDTH-1 : ADDR_WIDTH].
Dest_Reg  out  ADDR_WIDTH  head bits [ADDR_WIDTH-1 : 0].
Count  out  $clog2(DEPTH+1)  current occupancy.
RAW_Hazard  out  1  head reads the last issued destination register.

Behaviour:
- State: storage array, Wr_Ptr and Rd_Ptr (log2(DEPTH) bits, natural wrap), Count, Last_Dest, Last_Dest_Valid.
- Reset (async, any time, including mid-transfer): pointers = 0, Count = 0, Last_Dest = 0, Last_Dest_Valid = 0. Storage is not reset.
- Outputs after reset: IR_Valid = 0, IR_Ready = 1, all fields = 0, RAW_Hazard = 0.
- IR_Ready = (Count != DEPTH). IR_Valid = (Count != 0). Both decode from registers only and have no combinational path from inputs.
- Push = Ram_Inst_Valid & IR_Ready. Pop = IR_Valid & Decode_Ready.
- Latency: an instruction pushed at edge N appears on the fields with IR_Valid = 1 from edge N onward. There is no same-cycle bypass; an empty queue never forwards Ram_Inst_Out.
- Fields: slices of the entry at Rd_Ptr, forced to 0 when IR_Valid = 0.
- Push and pop in the same cycle: both happen and Count is unchanged; legal at any Count in 1..DEPTH-1.
- At Count = 0, only push can occur.
- At Count = DEPTH, IR_Ready = 0, so push is blocked; a pop in that cycle makes IR_Ready = 1 from the next cycle.
- Pop: Last_Dest <= Dest_Reg of the popped head, and Last_Dest_Valid <= 1.
- RAW_Hazard = IR_Valid & Last_Dest_Valid & (Source_Reg1 == Last_Dest | Source_Reg2 == Last_Dest). It is purely informational and the queue never stalls on it.
- Flush (synchronous, highest priority): pointers, Count and Last_Dest_Valid clear at the edge. Any push or pop in the same cycle is discarded, and Last_Dest is not updated.
- Ram_Inst_Out is sampled only on push, so values while Ram_Inst_Valid = 0 are don't-care.

Decomposition:
- Shared parameters include: OPCODE_WIDTH, ADDR_WIDTH, INST_WIDTH, field bit-position constants, default IR_DEPTH, plus bench knobs NUM_IR_TEST and DUTY/PERIOD.
- One sub-module, ir_queue_mem: DEPTH x INST_WIDTH storage with registered write, asynchronous read at Rd_Ptr, and no reset.
- Pointer, count and hazard logic stay in ir_queue.

Test Plan:
- Reset, then push 21'b101_000011_000101_000111 -> next cycle IR_Valid = 1, Opcode = 101, Source_Reg1 = 3, Source_Reg2 = 5, Dest_Reg = 7, Count = 1, RAW_Hazard = 0.
- Push 4 instructions with Decode_Ready = 0 -> Count = 4, IR_Ready = 0; a fifth offer is not accepted; popping then returns all 4 in FIFO order.
- Hold Count = 2, assert push and pop together for 10 cycles -> Count stays 2, output order preserved across pointer wrap.
- Pop the instruction with Dest = 7, next head has Source_Reg2 = 7 -> RAW_Hazard = 1; a head with sources 1 and 2 -> RAW_Hazard = 0.
- At Count = 3, assert Flush together with Ram_Inst_Valid and Decode_Ready -> next cycle Count = 0, IR_Valid = 0, fields = 0, RAW_Hazard = 0.
- Assert Reset asynchronously mid-cycle at Count = 2 -> IR_Valid falls immediately with no clock edge; after release, IR_Ready = 1 and a fresh push works.
